// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared definitions for the fetch queue unit: state encoding,
//               default long-opcode field and vector addresses, and a helper
//               that classifies an instruction byte as one- or two-byte.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_RSTVEC = 2'd1,
    S_RUN    = 2'd2,
    S_INTVEC = 2'd3
  } fetch_state_e;

  localparam logic [3:0]  LONG_OP_DEF = 4'hC;
  localparam int unsigned RST_VEC_DEF = 0;
  localparam int unsigned INT_VEC_DEF = 1;

  // A byte whose opcode field matches long_op starts a two-byte instruction.
  function automatic logic is_long_op(input logic [7:0] opc, input logic [3:0] long_op);
    return opc[7:4] == long_op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry prefetch queue of {byte, address} entries with
//               push, pop of one or two entries, flush and occupancy count.
//               Exposes the head entry and the byte of the entry behind it.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [8+ADDR_W-1:0]     push_data_i,
  input  logic                    pop1_i,
  input  logic                    pop2_i,
  output logic [8+ADDR_W-1:0]     head_o,
  output logic [7:0]              next_byte_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = 8 + ADDR_W;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_q;
  logic [PTR_W-1:0]   rd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   w_pop_num;
  logic [PTR_W-1:0]   w_rd_next;

  // Number of entries leaving the queue this cycle.
  always_comb begin
    w_pop_num = '0;
    if (pop2_i) begin
      w_pop_num = CNT_W'(2);
    end else if (pop1_i) begin
      w_pop_num = CNT_W'(1);
    end
  end

  // Pointer and occupancy bookkeeping; flush discards everything at once.
  always_ff @(posedge clk) begin
    if (!reset || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        wr_q <= wr_q + PTR_W'(1);
      end
      rd_q  <= rd_q + w_pop_num[PTR_W-1:0];
      cnt_q <= cnt_q + CNT_W'(push_i) - w_pop_num;
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  assign w_rd_next   = rd_q + PTR_W'(1);
  assign head_o      = mem_q[rd_q];
  assign next_byte_o = mem_q[w_rd_next][ENTRY_W-1 -: 8];
  assign count_o     = cnt_q;

endmodule
`default_nettype wire

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_unit
// Description : Instruction fetch front end. Loads the reset vector, then
//               streams bytes from instruction memory into a small prefetch
//               queue and presents complete one- or two-byte instructions to
//               decode. Handles redirects and, optionally, interrupt entry.
//               Build option: FETCH_QUEUE_INTR_EN enables interrupt logic.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DEPTH        = 4,
  parameter logic [3:0]  LONG_OP      = LONG_OP_DEF,
  parameter int unsigned RST_VEC_ADDR = RST_VEC_DEF,
  parameter int unsigned INT_VEC_ADDR = INT_VEC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        ir,
  output logic [7:0]        imm,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              redirect_rti,
  input  logic              intr,
  output logic              int_ack,
  output logic [ADDR_W-1:0] ret_addr
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = 8 + ADDR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic [ENTRY_W-1:0] w_head;
  logic [7:0]         w_head_byte;
  logic [ADDR_W-1:0]  w_head_pc;
  logic [7:0]         w_next_byte;
  logic [CNT_W-1:0]   w_count;
  logic               w_long;
  logic               w_full;
  logic               w_valid;
  logic               w_xfer;
  logic               w_push;
  logic               w_flush;

`ifdef FETCH_QUEUE_INTR_EN
  logic              ien_q, ien_d;
  logic              int_ack_q, int_ack_d;
  logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
  logic              w_int_entry;
`endif

  fetch_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (w_flush),
    .push_i      (w_push),
    .push_data_i ({mem_data, pc_q}),
    .pop1_i      (w_xfer && !w_long),
    .pop2_i      (w_xfer && w_long),
    .head_o      (w_head),
    .next_byte_o (w_next_byte),
    .count_o     (w_count)
  );

  assign w_head_byte = w_head[ENTRY_W-1 -: 8];
  assign w_head_pc   = w_head[ADDR_W-1:0];
  assign w_long      = is_long_op(w_head_byte, LONG_OP);
  assign w_valid     = w_long ? (w_count >= CNT_W'(2)) : (w_count != '0);
  assign w_full      = (w_count == CNT_W'(DEPTH));
  assign w_xfer      = w_valid && out_ready;

  // Outputs read zero whenever no complete instruction is presented.
  assign out_valid = w_valid;
  assign ir        = w_valid ? w_head_byte : '0;
  assign imm       = (w_valid && w_long) ? w_next_byte : '0;
  assign pc_out    = w_valid ? w_head_pc : '0;

`ifdef FETCH_QUEUE_INTR_EN
  // Interrupts are taken only between instructions, never over a redirect.
  assign w_int_entry = intr && ien_q && (state_q == S_RUN) && !redirect_valid && !w_xfer;
  assign int_ack     = int_ack_q;
  assign ret_addr    = ret_addr_q;
`else
  logic unused_intr_w;
  assign unused_intr_w = ^{intr, redirect_rti, ADDR_W'(INT_VEC_ADDR)};
  assign int_ack       = 1'b0;
  assign ret_addr      = '0;
`endif

  // Next state, fetch address and queue control; redirect beats interrupt beats fetch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mem_addr = pc_q;
    w_push   = 1'b0;
    w_flush  = 1'b0;
`ifdef FETCH_QUEUE_INTR_EN
    ien_d      = ien_q;
    int_ack_d  = 1'b0;
    ret_addr_d = ret_addr_q;
`endif
    case (state_q)
      S_RESET: begin
        state_d = S_RSTVEC;
      end
      S_RSTVEC: begin
        mem_addr = ADDR_W'(RST_VEC_ADDR);
        pc_d     = ADDR_W'(mem_data);
        state_d  = S_RUN;
      end
      S_RUN: begin
        if (redirect_valid) begin
          w_flush = 1'b1;
          pc_d    = redirect_addr;
`ifdef FETCH_QUEUE_INTR_EN
          if (redirect_rti) ien_d = 1'b1;
`endif
        end
`ifdef FETCH_QUEUE_INTR_EN
        else if (w_int_entry) begin
          w_flush    = 1'b1;
          int_ack_d  = 1'b1;
          ret_addr_d = (w_count != '0) ? w_head_pc : pc_q;
          ien_d      = 1'b0;
          state_d    = S_INTVEC;
        end
`endif
        else if (!w_full) begin
          w_push = 1'b1;
          pc_d   = pc_q + ADDR_W'(1);
        end
      end
`ifdef FETCH_QUEUE_INTR_EN
      S_INTVEC: begin
        state_d = S_RUN;
        if (redirect_valid) begin
          w_flush = 1'b1;
          pc_d    = redirect_addr;
          if (redirect_rti) ien_d = 1'b1;
        end else begin
          mem_addr = ADDR_W'(INT_VEC_ADDR);
          pc_d     = ADDR_W'(mem_data);
        end
      end
`endif
      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  // State, fetch PC and interrupt bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_RESET;
      pc_q    <= '0;
`ifdef FETCH_QUEUE_INTR_EN
      ien_q      <= 1'b1;
      int_ack_q  <= 1'b0;
      ret_addr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef FETCH_QUEUE_INTR_EN
      ien_q      <= ien_d;
      int_ack_q  <= int_ack_d;
      ret_addr_q <= ret_addr_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue_unit
// Description : Directed vector bench for fetch_queue_unit. A cycle table
//               covers reset, streaming, two-byte instructions, back-pressure
//               and redirect; hand-written sequences cover interrupt entry,
//               reset override and PC wrap on a 4-bit address instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ready = 1'b1;
  logic       redir = 1'b0;
  logic [7:0] raddr = '0;
  logic       rti = 1'b0;
  logic       intr = 1'b0;

  logic [7:0] mem_addr, mem_data, ir, imm, pc_out, ret_addr;
  logic       out_valid, int_ack;

  logic       rst4 = 1'b0;
  logic [3:0] ma4, pc4, ret4;
  logic [7:0] md4, ir4, imm4;
  logic       v4, ack4;

  logic [7:0] mem8 [256];
  logic [7:0] mem4 [16];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  assign mem_data = mem8[mem_addr];
  assign md4      = mem4[ma4];

  fetch_queue_unit u_dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(ready), .ir(ir), .imm(imm), .pc_out(pc_out),
    .redirect_valid(redir), .redirect_addr(raddr), .redirect_rti(rti),
    .intr(intr), .int_ack(int_ack), .ret_addr(ret_addr)
  );

  fetch_queue_unit #(.ADDR_W(4)) u_dut4 (
    .clk(clk), .reset(rst4), .mem_addr(ma4), .mem_data(md4),
    .out_valid(v4), .out_ready(1'b1), .ir(ir4), .imm(imm4), .pc_out(pc4),
    .redirect_valid(1'b0), .redirect_addr(4'h0), .redirect_rti(1'b0),
    .intr(1'b0), .int_ack(ack4), .ret_addr(ret4)
  );

  typedef struct {
    logic       rst_n;
    logic       rdy;
    logic       rv;
    logic [7:0] ra;
    logic       exp_v;
    logic [7:0] exp_ir;
    logic [7:0] exp_imm;
    logic [7:0] exp_pc;
    logic [7:0] exp_ma;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(logic rd, logic rv, logic [7:0] ra, logic v,
                              logic [7:0] i, logic [7:0] m, logic [7:0] p, logic [7:0] a);
    vec_t t;
    t.rst_n = 1'b1; t.rdy = rd; t.rv = rv; t.ra = ra;
    t.exp_v = v; t.exp_ir = i; t.exp_imm = m; t.exp_pc = p; t.exp_ma = a;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    logic ack_seen;
    for (int a = 0; a < 256; a++) mem8[a] = 8'h40 | (8'(a) & 8'h3F);
    mem8[8'h00] = 8'h10;
    mem8[8'h01] = 8'h70;
    mem8[8'h12] = 8'hC1;
    mem8[8'h13] = 8'h55;
    for (int a = 0; a < 16; a++) mem4[a] = 8'h20 | 8'(a);
    mem4[4'h0] = 8'h0F;
    mem4[4'hF] = 8'hC7;

    // Row k: outputs expected in cycle k, inputs driven during cycle k.
    tbl[0]  = mk(1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[1]  = mk(1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[2]  = mk(1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h10);
    tbl[3]  = mk(1, 0, 8'h00, 1, 8'h50, 8'h00, 8'h10, 8'h11);
    tbl[4]  = mk(1, 0, 8'h00, 1, 8'h51, 8'h00, 8'h11, 8'h12);
    tbl[5]  = mk(1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h13);
    tbl[6]  = mk(1, 0, 8'h00, 1, 8'hC1, 8'h55, 8'h12, 8'h14);
    tbl[7]  = mk(0, 0, 8'h00, 1, 8'h54, 8'h00, 8'h14, 8'h15);
    tbl[8]  = mk(0, 0, 8'h00, 1, 8'h54, 8'h00, 8'h14, 8'h16);
    tbl[9]  = mk(0, 0, 8'h00, 1, 8'h54, 8'h00, 8'h14, 8'h17);
    for (int k = 10; k <= 16; k++) tbl[k] = mk(0, 0, 8'h00, 1, 8'h54, 8'h00, 8'h14, 8'h18);
    tbl[17] = mk(1, 0, 8'h00, 1, 8'h54, 8'h00, 8'h14, 8'h18);
    tbl[18] = mk(1, 0, 8'h00, 1, 8'h55, 8'h00, 8'h15, 8'h18);
    tbl[19] = mk(0, 0, 8'h00, 1, 8'h56, 8'h00, 8'h16, 8'h19);
    tbl[20] = mk(1, 1, 8'h40, 1, 8'h56, 8'h00, 8'h16, 8'h1A);
    tbl[21] = mk(1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h40);
    tbl[22] = mk(1, 0, 8'h00, 1, 8'h40, 8'h00, 8'h40, 8'h41);
    tbl[23] = mk(1, 0, 8'h00, 1, 8'h41, 8'h00, 8'h41, 8'h42);

    repeat (3) @(posedge clk);

    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      chk($sformatf("row%0d", k),
          {out_valid, ir, imm, pc_out, mem_addr},
          {tbl[k].exp_v, tbl[k].exp_ir, tbl[k].exp_imm, tbl[k].exp_pc, tbl[k].exp_ma});
      reset = tbl[k].rst_n;
      ready = tbl[k].rdy;
      redir = tbl[k].rv;
      raddr = tbl[k].ra;
    end

    // Interrupt request while the head instruction sits at 0x21.
    @(negedge clk); redir = 1'b1; raddr = 8'h21; ready = 1'b0;
    @(negedge clk); redir = 1'b0;
    @(negedge clk);
    chk("irq_head", {out_valid, pc_out}, {1'b1, 8'h21});
    intr = 1'b1;
    @(negedge clk);
`ifdef FETCH_QUEUE_INTR_EN
    chk("irq_ack", {int_ack, ret_addr, out_valid, mem_addr}, {1'b1, 8'h21, 1'b0, 8'h01});
    ready = 1'b1;
    @(negedge clk);
    chk("irq_pulse", {int_ack, mem_addr}, {1'b0, 8'h70});
    @(negedge clk);
    chk("irq_vec", {out_valid, ir, pc_out}, {1'b1, 8'h70, 8'h70});
    ack_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (int_ack) ack_seen = 1'b1;
    end
    chk("irq_masked", {63'd0, ack_seen}, 64'd0);
    redir = 1'b1; raddr = 8'h21; rti = 1'b1;
    @(negedge clk); redir = 1'b0; rti = 1'b0;
    @(negedge clk);
    chk("irq_rearm", {int_ack, ret_addr}, {1'b1, 8'h21});
`else
    chk("irq_off", {int_ack, ret_addr, out_valid, pc_out}, {1'b0, 8'h00, 1'b1, 8'h21});
    @(negedge clk);
    chk("irq_off2", {int_ack, ret_addr, out_valid, pc_out}, {1'b0, 8'h00, 1'b1, 8'h21});
`endif
    intr = 1'b0;

    // Reset wins over a simultaneous redirect and interrupt request.
    @(negedge clk); reset = 1'b0; redir = 1'b1; raddr = 8'h99; intr = 1'b1; ready = 1'b1;
    @(negedge clk);
    chk("rst_override", {out_valid, ir, imm, pc_out, int_ack, ret_addr, mem_addr}, 57'd0);
    redir = 1'b0; intr = 1'b0;

    // Four-bit address instance: two-byte instruction straddling the wrap.
    chk("rst4", {v4, ir4, imm4, pc4, ma4, ack4, ret4}, 30'd0);
    rst4 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (v4) break;
    end
    chk("wrap_long", {v4, ir4, imm4, pc4}, {1'b1, 8'hC7, 8'h0F, 4'hF});
    @(negedge clk);
    chk("wrap_next", {v4, ir4, imm4, pc4}, {1'b1, 8'h21, 8'h00, 4'h1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
